neuron_scheduler: RTL and testbench
===================================

// Module: neuron_scheduler
// PURPOSE
//  Shares one Neuron datapath (linear CORDIC, then hyperbolic CORDIC) between N requesters.
//  Round-robin grants one request at a time and drives the Neuron operands.
//  Pulses the Neuron restart, waits for its complete flag (with a watchdog), and returns
//  Sin_H/Cos_H/Z tagged with the requester id over a valid/ready response port.
// PARAMETERS
//  WIDTH      15   MSB index of data words (data is WIDTH+1 bits, matches Neuron)
//  N          4    number of requesters, 2..8
//  IDW        2    requester id width, >= clog2(N)
//  RST_CYCLES 2    cycles nrn_rst is held high after operands load, >= 1
//  TIMEOUT    64   max RUN cycles before abort, < 2^8
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  req_valid    in   N          request pending, per requester
//  req_ready    out  N          one-hot grant; transfer when req_valid[i]&req_ready[i]
//  req_x/y/z    in   N*(WIDTH+1) each; flattened operands, requester i at [i*(WIDTH+1)+:WIDTH+1]
//  rsp_valid    out  1          result available
//  rsp_ready    in   1          consumer accepts result
//  rsp_id       out  IDW        requester index of this result
//  rsp_sinh/rsp_cosh/rsp_z  out  WIDTH+1 each; captured Neuron Sin_H / Cos_H / Z
//  rsp_timeout  out  1          result aborted by watchdog, data fields are 0
//  nrn_x/y/z    out  WIDTH+1 each; Neuron Xo/Yo/Zo, registered
//  nrn_rst      out  1          Neuron reset, active-high
//  nrn_complete in   1          Neuron complete flag
//  nrn_sinh/nrn_cosh/nrn_zr  in  WIDTH+1 each; Neuron Sin_H/Cos_H/Z
//  busy         out  1          state != IDLE
//  to_count     out  8          saturating count of timeouts
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE, last_grant=N-1, nrn_rst=1.
//   All other outputs, operand regs and counters are 0.
//  FSM IDLE -> START -> RUN -> RESP -> IDLE.
//  IDLE:
//   - req_ready is one-hot, combinational, asserted only in IDLE: the first i with
//     req_valid[i]=1, searching last_grant+1 .. last_grant+N mod N.
//   - All zero when no requests.
//   - On the handshake: latch operands to nrn_x/y/z, rsp_id=i, last_grant=i, go START.
//  START: nrn_rst=1 for exactly RST_CYCLES cycles. nrn_complete is ignored, since it is stale.
//  RUN:
//   - nrn_rst=0; cyc counter starts at 0 and increments each cycle.
//   - nrn_complete=1 sampled: capture nrn_sinh/cosh/zr to rsp_*, rsp_timeout=0, go RESP.
//   - Else cyc==TIMEOUT-1: rsp_* data=0, rsp_timeout=1, to_count+=1 (saturates at 255),
//     go RESP.
//   - Complete and timeout in the same cycle: complete wins.
//  RESP:
//   - rsp_valid=1, nrn_rst=1.
//   - rsp_* held stable until rsp_valid&rsp_ready, then IDLE with rsp_valid=0 next cycle.
//   - New requests are not granted during RESP.
//  nrn_rst is 1 in IDLE/START/RESP and 0 only in RUN; the datapath is parked when unused.
//  Latency: handshake at cycle 0 -> RUN entered at cycle RST_CYCLES+1.
//   Result visible the cycle after complete is sampled.
//  Operands stay stable on nrn_x/y/z from load until the next grant.
//  req_valid dropped before grant: nothing happens. Requester inputs are never sampled
//   outside the IDLE handshake.
//  reset asserted mid-operation: immediate return to reset state; in-flight result is
//   discarded, no rsp_valid.
//  The timeout counter is free of wrap: cyc never exceeds TIMEOUT-1.
// TESTING
//  1. Single req0 x=0x1000 y=0 z=0x0800; model complete after 20 cycles with sinh=0x0123
//     -> rsp_valid with id=0, sinh=0x0123, timeout=0; nrn_rst low for exactly 20 RUN cycles.
//  2. req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; ids match; one job at a time.
//  3. Model never completes -> rsp_timeout=1 after 64 RUN cycles, data 0, to_count=1;
//     next request then succeeds.
//  4. rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready stays 0000,
//     completes on rsp_ready=1.
//  5. reset pulled low during RUN -> outputs 0 and nrn_rst=1 asynchronously;
//     after release, req2 is granted and id=2.
//  6. nrn_complete held 1 from the previous job through START -> ignored;
//     first RUN-cycle sample accepted.

Source files
------------

// File: rtl/neuron_scheduler_if.sv
// Request/response bundle between N requesters, the neuron scheduler and the result consumer.
// master = requester/consumer side, slave = scheduler side.
interface neuron_scheduler_if #(
    parameter int WIDTH = 15,
    parameter int N     = 4,
    parameter int IDW   = 2
);
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N*(WIDTH+1)-1:0] req_x;
    logic [N*(WIDTH+1)-1:0] req_y;
    logic [N*(WIDTH+1)-1:0] req_z;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH:0]         rsp_sinh;
    logic [WIDTH:0]         rsp_cosh;
    logic [WIDTH:0]         rsp_z;
    logic                   rsp_timeout;

    modport master (
        output req_valid, req_x, req_y, req_z, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sinh, rsp_cosh, rsp_z, rsp_timeout
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sinh, rsp_cosh, rsp_z, rsp_timeout
    );
endinterface

// File: rtl/neuron_scheduler.sv
// Round-robin arbiter sharing one Neuron CORDIC datapath between N requesters,
// with restart sequencing, a completion watchdog and a tagged valid/ready result port.
module neuron_scheduler #(
    parameter int WIDTH      = 15,
    parameter int N          = 4,
    parameter int IDW        = 2,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    neuron_scheduler_if.slave bus,
    output logic [WIDTH:0]    nrn_x,
    output logic [WIDTH:0]    nrn_y,
    output logic [WIDTH:0]    nrn_z,
    output logic              nrn_rst,
    input  logic              nrn_complete,
    input  logic [WIDTH:0]    nrn_sinh,
    input  logic [WIDTH:0]    nrn_cosh,
    input  logic [WIDTH:0]    nrn_zr,
    output logic              busy,
    output logic [7:0]        to_count
);
    localparam int DW  = WIDTH + 1;
    localparam int RW  = IDW + 1;
    localparam int SW  = IDW + 3 * DW;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RW-1:0]  RANK_ONE = RW'(1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [7:0]     CYC_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_grant_q;
    logic [RCW-1:0]   rst_cnt_q;
    logic [7:0]       cyc_q;
    logic [7:0]       to_count_q;
    logic [7:0]       to_count_d;
    logic             nrn_rst_q;
    logic [WIDTH:0]   nrn_x_q;
    logic [WIDTH:0]   nrn_y_q;
    logic [WIDTH:0]   nrn_z_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH:0]   rsp_sinh_q;
    logic [WIDTH:0]   rsp_cosh_q;
    logic [WIDTH:0]   rsp_z_q;
    logic             rsp_timeout_q;

    logic [RW-1:0]    lg_ext;
    logic [RW-1:0]    rank [N];
    logic [N-1:0]     beats [N];
    logic [N-1:0]     grant_oh;
    logic             grant_any;
    logic [SW-1:0]    sel_term [N];
    logic [SW-1:0]    sel_acc [N];
    logic [IDW-1:0]   sel_id;
    logic [WIDTH:0]   sel_x;
    logic [WIDTH:0]   sel_y;
    logic [WIDTH:0]   sel_z;

    assign lg_ext = {1'b0, last_grant_q};

    // rank = distance after last_grant (0 = next in turn); lowest-ranked valid requester wins
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            localparam logic [RW-1:0] POS = RW'(gi);
            localparam logic [RW-1:0] NN  = RW'(N);

            assign rank[gi] = (POS > lg_ext) ? (POS - lg_ext - RANK_ONE)
                                             : (POS + NN - lg_ext - RANK_ONE);

            for (genvar gj = 0; gj < N; gj++) begin : g_cmp
                assign beats[gi][gj] = bus.req_valid[gj] && (rank[gj] < rank[gi]);
            end

            assign grant_oh[gi] = (state_q == IDLE) && bus.req_valid[gi] && !(|beats[gi]);

            assign sel_term[gi] = grant_oh[gi] ? {IDW'(gi),
                                                  bus.req_x[gi*DW +: DW],
                                                  bus.req_y[gi*DW +: DW],
                                                  bus.req_z[gi*DW +: DW]} : '0;

            if (gi == 0) begin : g_first
                assign sel_acc[gi] = sel_term[gi];
            end else begin : g_chain
                assign sel_acc[gi] = sel_acc[gi-1] | sel_term[gi];
            end
        end
    endgenerate

    assign grant_any                      = |grant_oh;
    assign {sel_id, sel_x, sel_y, sel_z} = sel_acc[N-1];
    assign to_count_d = (to_count_q == 8'hFF) ? to_count_q : to_count_q + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(N - 1);
            rst_cnt_q     <= '0;
            cyc_q         <= '0;
            to_count_q    <= '0;
            nrn_rst_q     <= 1'b1;
            nrn_x_q       <= '0;
            nrn_y_q       <= '0;
            nrn_z_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_sinh_q    <= '0;
            rsp_cosh_q    <= '0;
            rsp_z_q       <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    nrn_rst_q <= 1'b1;
                    if (grant_any) begin
                        nrn_x_q      <= sel_x;
                        nrn_y_q      <= sel_y;
                        nrn_z_q      <= sel_z;
                        rsp_id_q     <= sel_id;
                        last_grant_q <= sel_id;
                        rst_cnt_q    <= '0;
                        state_q      <= START;
                    end
                end
                // nrn_complete is left over from the previous job here, so it is not looked at
                START: begin
                    if (rst_cnt_q == RST_LAST) begin
                        nrn_rst_q <= 1'b0;
                        cyc_q     <= '0;
                        state_q   <= RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RCW'(1);
                    end
                end
                RUN: begin
                    if (nrn_complete) begin
                        rsp_sinh_q    <= nrn_sinh;
                        rsp_cosh_q    <= nrn_cosh;
                        rsp_z_q       <= nrn_zr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        nrn_rst_q     <= 1'b1;
                        state_q       <= RESP;
                    end else if (cyc_q == CYC_LAST) begin
                        rsp_sinh_q    <= '0;
                        rsp_cosh_q    <= '0;
                        rsp_z_q       <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        nrn_rst_q     <= 1'b1;
                        to_count_q    <= to_count_d;
                        state_q       <= RESP;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = grant_oh;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_sinh    = rsp_sinh_q;
    assign bus.rsp_cosh    = rsp_cosh_q;
    assign bus.rsp_z       = rsp_z_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    assign nrn_x    = nrn_x_q;
    assign nrn_y    = nrn_y_q;
    assign nrn_z    = nrn_z_q;
    assign nrn_rst  = nrn_rst_q;
    assign busy     = (state_q != IDLE);
    assign to_count = to_count_q;
endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler with a behavioural Neuron stand-in:
// sinh = y + 0x0123, cosh = x + 1, zr = z >> 1, complete after m_lat RUN cycles.
module tb_neuron_scheduler;
    localparam int WIDTH = 15;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int DW    = WIDTH + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    neuron_scheduler_if #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) ifc ();

    logic [WIDTH:0] nrn_x, nrn_y, nrn_z;
    logic           nrn_rst;
    logic           nrn_complete;
    logic [WIDTH:0] nrn_sinh, nrn_cosh, nrn_zr;
    logic           busy;
    logic [7:0]     to_count;

    neuron_scheduler #(
        .WIDTH(WIDTH), .N(N), .IDW(IDW), .RST_CYCLES(2), .TIMEOUT(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (ifc.slave),
        .nrn_x        (nrn_x),
        .nrn_y        (nrn_y),
        .nrn_z        (nrn_z),
        .nrn_rst      (nrn_rst),
        .nrn_complete (nrn_complete),
        .nrn_sinh     (nrn_sinh),
        .nrn_cosh     (nrn_cosh),
        .nrn_zr       (nrn_zr),
        .busy         (busy),
        .to_count     (to_count)
    );

    typedef struct {
        int          id;
        logic [15:0] sinh;
        logic [15:0] cosh;
        logic [15:0] z;
        bit          to;
        int          runs;
        logic [15:0] nx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Neuron stand-in
    int m_lat   = 3;
    bit m_hang  = 1'b0;
    bit m_stuck = 1'b0;
    int m_cnt   = 0;

    assign nrn_sinh = nrn_y + 16'h0123;
    assign nrn_cosh = nrn_x + 16'h0001;
    assign nrn_zr   = nrn_z >> 1;

    initial begin
        nrn_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (m_stuck) begin
                nrn_complete = 1'b1;
            end else if (nrn_rst) begin
                m_cnt        = 0;
                nrn_complete = 1'b0;
            end else begin
                m_cnt++;
                nrn_complete = !m_hang && (m_cnt >= m_lat);
            end
        end
    end

    // Response monitor: pops the scoreboard on every accepted result
    initial begin
        int          runs;
        bit          held;
        logic [15:0] s_sinh, s_cosh, s_z;
        logic [1:0]  s_id;
        logic        s_to;
        exp_t        e;
        runs = 0;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                runs = 0;
                held = 1'b0;
            end else begin
                if (!nrn_rst) runs++;
                if (ifc.rsp_valid) begin
                    check("req_ready_during_resp", ifc.req_ready, 0);
                    if (held) begin
                        check("hold_id",   ifc.rsp_id,      s_id);
                        check("hold_sinh", ifc.rsp_sinh,    s_sinh);
                        check("hold_cosh", ifc.rsp_cosh,    s_cosh);
                        check("hold_z",    ifc.rsp_z,       s_z);
                        check("hold_to",   ifc.rsp_timeout, s_to);
                    end
                    s_id   = ifc.rsp_id;
                    s_sinh = ifc.rsp_sinh;
                    s_cosh = ifc.rsp_cosh;
                    s_z    = ifc.rsp_z;
                    s_to   = ifc.rsp_timeout;
                    if (ifc.rsp_ready) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_rsp: got id %0d, expected no response", ifc.rsp_id);
                        end else begin
                            e = q.pop_front();
                            check("rsp_id",      ifc.rsp_id,      e.id);
                            check("rsp_sinh",    ifc.rsp_sinh,    e.sinh);
                            check("rsp_cosh",    ifc.rsp_cosh,    e.cosh);
                            check("rsp_z",       ifc.rsp_z,       e.z);
                            check("rsp_timeout", ifc.rsp_timeout, e.to);
                            check("run_cycles",  runs,            e.runs);
                            check("nrn_x_kept",  nrn_x,           e.nx);
                            $display("rsp id=%0d sinh=%04h cosh=%04h z=%04h to=%0d runs=%0d",
                                     ifc.rsp_id, ifc.rsp_sinh, ifc.rsp_cosh, ifc.rsp_z,
                                     ifc.rsp_timeout, runs);
                        end
                        runs = 0;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic wait_grant(input int i);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (ifc.req_ready[i]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("grant_wait", got, 1);
        @(posedge clk);
        #1;
        ifc.req_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z);
        ifc.req_x[i*DW +: DW] = x;
        ifc.req_y[i*DW +: DW] = y;
        ifc.req_z[i*DW +: DW] = z;
        ifc.req_valid[i]      = 1'b1;
    endtask

    task automatic issue(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input bit push, input logic [15:0] es,
                         input logic [15:0] ec, input logic [15:0] ez, input bit to,
                         input int runs);
        exp_t e;
        @(negedge clk);
        set_req(i, x, y, z);
        if (push) begin
            e = '{i, es, ec, ez, to, runs, x};
            q.push_back(e);
        end
        wait_grant(i);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, 1);
    endtask

    logic [15:0] tx [4] = '{16'h0010, 16'h1111, 16'hAAAA, 16'hFFFF};
    logic [15:0] ty [4] = '{16'h0020, 16'h2222, 16'h0F00, 16'hFFFF};
    logic [15:0] tz [4] = '{16'h0030, 16'h4444, 16'h00FF, 16'h8000};
    logic [15:0] es [4] = '{16'h0143, 16'h2345, 16'h1023, 16'h0122};
    logic [15:0] ec [4] = '{16'h0011, 16'h1112, 16'hAAAB, 16'h0000};
    logic [15:0] ez [4] = '{16'h0018, 16'h2222, 16'h007F, 16'h4000};
    int          ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL global_watchdog: got no finish, expected finish before t=200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   g;
        bit   seen;
        exp_t e;
        ifc.req_valid = '0;
        ifc.req_x     = '0;
        ifc.req_y     = '0;
        ifc.req_z     = '0;
        ifc.rsp_ready = 1'b1;
        reset         = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_req_ready", ifc.req_ready, 0);
        check("rst_busy",      busy,          0);
        check("rst_nrn_rst",   nrn_rst,       1);
        check("rst_to_count",  to_count,      0);
        check("rst_nrn_x",     nrn_x,         0);
        check("rst_rsp_id",    ifc.rsp_id,    0);
        @(negedge clk);
        reset = 1'b1;

        // all four held: round-robin from last_grant=3 gives 0,1,2,3,0
        m_lat = 3;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, tx[i], ty[i], tz[i]);
        for (int k = 0; k < 5; k++) begin
            e = '{ord[k], es[ord[k]], ec[ord[k]], ez[ord[k]], 1'b0, 3, tx[ord[k]]};
            q.push_back(e);
        end
        g = 0;
        for (int c = 0; c < 400 && g < 5; c++) begin
            #1;
            if (ifc.req_ready != '0) begin
                check("grant_order", ifc.req_ready, 32'(1) << ord[g]);
                g++;
                if (g == 5) begin
                    @(posedge clk);
                    #1;
                    ifc.req_valid = '0;
                end
            end
            if (g < 5) @(negedge clk);
        end
        check("grant_count", g, 5);
        drain();

        // single job, 20 RUN cycles
        m_lat = 20;
        issue(0, 16'h1000, 16'h0000, 16'h0800, 1'b1, 16'h0123, 16'h1001, 16'h0400, 1'b0, 20);
        drain();

        // watchdog abort, then a normal job on the same requester
        m_hang = 1'b1;
        issue(3, 16'h1234, 16'h5678, 16'h0100, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 64);
        drain();
        check("to_count_after_timeout", to_count, 1);
        m_hang = 1'b0;
        m_lat  = 5;
        issue(3, 16'h1234, 16'h5678, 16'h0100, 1'b1, 16'h579B, 16'h1235, 16'h0080, 1'b0, 5);
        drain();

        // consumer back-pressure for 10 cycles while another request waits
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        issue(0, 16'h0200, 16'h0300, 16'h0400, 1'b1, 16'h0423, 16'h0201, 16'h0200, 1'b0, 5);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (ifc.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_valid_seen", seen, 1);
        set_req(1, 16'h0001, 16'h0002, 16'h0006);
        e = '{1, 16'h0125, 16'h0002, 16'h0003, 1'b0, 5, 16'h0001};
        q.push_back(e);
        repeat (10) begin
            @(negedge clk);
            #1;
            check("req_ready_blocked", ifc.req_ready, 0);
        end
        @(negedge clk);
        ifc.rsp_ready = 1'b1;
        wait_grant(1);
        drain();

        // complete stuck high across jobs: only the first RUN-cycle sample counts
        m_stuck = 1'b1;
        issue(2, 16'h0040, 16'h0050, 16'h0060, 1'b1, 16'h0173, 16'h0041, 16'h0030, 1'b0, 1);
        issue(1, 16'h0700, 16'h0800, 16'h0900, 1'b1, 16'h0923, 16'h0701, 16'h0480, 1'b0, 1);
        drain();
        m_stuck = 1'b0;

        // reset mid-RUN discards the job
        m_lat = 30;
        issue(1, 16'h0ABC, 16'h0DEF, 16'h0FFF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (!nrn_rst) begin
                seen = 1'b1;
                break;
            end
        end
        check("run_entered", seen, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_rsp_valid", ifc.rsp_valid, 0);
        check("arst_busy",      busy,          0);
        check("arst_nrn_rst",   nrn_rst,       1);
        check("arst_nrn_x",     nrn_x,         0);
        check("arst_to_count",  to_count,      0);
        check("arst_rsp_id",    ifc.rsp_id,    0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_lat = 4;
        issue(2, 16'h0003, 16'h0004, 16'h0008, 1'b1, 16'h0127, 16'h0004, 16'h0004, 1'b0, 4);
        drain();

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
